// File: rtl/calc_reg_sequencer.sv
// Calculator register-bank initiator: loads operands into the bank, reads them back,
// runs the ALU operation and writes the result into the accumulator register.
module calc_reg_sequencer #(
  parameter logic [1:0] ID_A   = 2'b00,
  parameter logic [1:0] ID_B   = 2'b01,
  parameter logic [1:0] ID_ACC = 2'b10
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_start,
  input  logic [2:0]  i_op,
  input  logic [31:0] i_op_a,
  input  logic [31:0] i_op_b,
  output logic [1:0]  o_id_reg,
  output logic        o_escrita,
  output logic [31:0] o_dado,
  output logic [1:0]  o_fonte1,
  output logic [1:0]  o_fonte2,
  input  logic [31:0] i_dado_lido1,
  input  logic [31:0] i_dado_lido2,
  output logic [31:0] o_resultado,
  output logic        o_pronto,
  output logic        o_ocupado,
  output logic        o_overflow
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WR_A   = 3'd1,
    S_WR_B   = 3'd2,
    S_RD     = 3'd3,
    S_EXEC   = 3'd4,
    S_WR_ACC = 3'd5,
    S_DONE   = 3'd6
  } state_t;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_SLT = 3'b100;
  localparam logic [2:0] OP_ACC = 3'b101;

  state_t      r_state, w_next_state;
  logic [2:0]  r_op, w_op_n;
  logic [31:0] r_op_a, r_op_b, w_op_a_n, w_op_b_n;
  logic [31:0] r_x, r_y;
  logic [31:0] w_alu_r;
  logic        w_alu_ovf, w_accept;
  logic [1:0]  w_id_reg, w_fonte1, w_fonte2;
  logic        w_escrita, w_pronto, w_ocupado;
  logic [31:0] w_dado;

  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start && (i_op[2:1] != 2'b11)) begin
          w_accept     = 1'b1;
          w_next_state = (i_op == OP_ACC) ? S_WR_B : S_WR_A;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_WR_A:   w_next_state = S_WR_B;
      S_WR_B:   w_next_state = S_RD;
      S_RD:     w_next_state = S_EXEC;
      S_EXEC:   w_next_state = S_WR_ACC;
      S_WR_ACC: w_next_state = S_DONE;
      S_DONE:   w_next_state = S_IDLE;
      default:  w_next_state = S_IDLE;
    endcase
  end

  assign w_op_n   = w_accept ? i_op   : r_op;
  assign w_op_a_n = w_accept ? i_op_a : r_op_a;
  assign w_op_b_n = w_accept ? i_op_b : r_op_b;

  // Outputs are decoded from the next state so the registered copies line up with r_state.
  always_comb begin
    w_escrita = 1'b0;
    w_id_reg  = 2'b00;
    w_dado    = 32'd0;
    w_fonte1  = ID_A;
    w_fonte2  = ID_B;
    w_pronto  = 1'b0;
    w_ocupado = (w_next_state != S_IDLE);
    case (w_next_state)
      S_WR_A: begin
        w_escrita = 1'b1;
        w_id_reg  = ID_A;
        w_dado    = w_op_a_n;
      end
      S_WR_B: begin
        w_escrita = 1'b1;
        w_id_reg  = ID_B;
        w_dado    = w_op_b_n;
      end
      S_RD:     w_fonte1 = (w_op_n == OP_ACC) ? ID_ACC : ID_A;
      S_WR_ACC: begin
        w_escrita = 1'b1;
        w_id_reg  = ID_ACC;
        w_dado    = w_alu_r;
      end
      S_DONE:   w_pronto = 1'b1;
      default:  w_pronto = 1'b0;
    endcase
  end

  always_comb begin
    w_alu_r   = 32'd0;
    w_alu_ovf = 1'b0;
    case (r_op)
      OP_ADD, OP_ACC: begin
        w_alu_r   = r_x + r_y;
        w_alu_ovf = (r_x[31] == r_y[31]) && (w_alu_r[31] != r_x[31]);
      end
      OP_SUB: begin
        w_alu_r   = r_x - r_y;
        w_alu_ovf = (r_x[31] != r_y[31]) && (w_alu_r[31] != r_x[31]);
      end
      OP_AND:  w_alu_r = r_x & r_y;
      OP_OR:   w_alu_r = r_x | r_y;
      OP_SLT:  w_alu_r = ($signed(r_x) < $signed(r_y)) ? 32'd1 : 32'd0;
      default: w_alu_r = 32'd0;
    endcase
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_op        <= 3'd0;
      r_op_a      <= 32'd0;
      r_op_b      <= 32'd0;
      r_x         <= 32'd0;
      r_y         <= 32'd0;
      o_id_reg    <= 2'b00;
      o_escrita   <= 1'b0;
      o_dado      <= 32'd0;
      o_fonte1    <= 2'b00;
      o_fonte2    <= 2'b00;
      o_resultado <= 32'd0;
      o_pronto    <= 1'b0;
      o_ocupado   <= 1'b0;
      o_overflow  <= 1'b0;
    end else begin
      r_state   <= w_next_state;
      r_op      <= w_op_n;
      r_op_a    <= w_op_a_n;
      r_op_b    <= w_op_b_n;
      o_id_reg  <= w_id_reg;
      o_escrita <= w_escrita;
      o_dado    <= w_dado;
      o_fonte1  <= w_fonte1;
      o_fonte2  <= w_fonte2;
      o_pronto  <= w_pronto;
      o_ocupado <= w_ocupado;
      if (r_state == S_RD) begin
        r_x <= i_dado_lido1;
        r_y <= i_dado_lido2;
      end
      if (w_accept) begin
        o_overflow <= 1'b0;
      end else if (r_state == S_EXEC) begin
        o_overflow <= w_alu_ovf;
      end
      // o_dado carries R throughout WR_ACC, so the result lands with the bank write.
      if (r_state == S_WR_ACC) begin
        o_resultado <= o_dado;
      end
    end
  end

endmodule

// File: tb/tb_calc_reg_sequencer.sv
// Directed + random bench for calc_reg_sequencer with a behavioural register bank
// and an arithmetic reference model of each operation.
module tb_calc_reg_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start;
  logic [2:0]  op;
  logic [31:0] op_a, op_b;
  logic [1:0]  id_reg, fonte1, fonte2;
  logic        escrita, pronto, ocupado, overflow;
  logic [31:0] dado, rd1, rd2, resultado;

  logic [31:0] bank [4] = '{default: 32'd0};
  logic [33:0] wlog [$];
  logic [31:0] model_acc = 32'd0;
  int          vectors = 0;
  int          miscompares = 0;

  always #5 clk = ~clk;

  calc_reg_sequencer dut (
    .i_clock(clk), .i_reset(rst), .i_start(start), .i_op(op),
    .i_op_a(op_a), .i_op_b(op_b), .o_id_reg(id_reg), .o_escrita(escrita),
    .o_dado(dado), .o_fonte1(fonte1), .o_fonte2(fonte2),
    .i_dado_lido1(rd1), .i_dado_lido2(rd2), .o_resultado(resultado),
    .o_pronto(pronto), .o_ocupado(ocupado), .o_overflow(overflow)
  );

  assign rd1 = bank[fonte1];
  assign rd2 = bank[fonte2];

  always @(posedge clk) begin
    if (escrita) begin
      bank[id_reg] <= dado;
      wlog.push_back({id_reg, dado});
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: {overflow, result} from signed/unsigned arithmetic on the operand values.
  function automatic logic [32:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, t;
    logic [31:0] r;
    bit v;
    sx = $signed(x);
    sy = $signed(y);
    t = 64'sd0;
    v = 1'b0;
    r = 32'd0;
    case (o)
      3'd0, 3'd5: begin t = sx + sy; r = x + y; end
      3'd1: begin t = sx - sy; r = x - y; end
      3'd2: r = x & y;
      3'd3: r = x | y;
      3'd4: r = (sx < sy) ? 32'd1 : 32'd0;
      default: r = 32'd0;
    endcase
    if (o == 3'd0 || o == 3'd1 || o == 3'd5)
      v = (t > 64'sd2147483647) || (t < -64'sd2147483648);
    return {v, r};
  endfunction

  task automatic check_all_zero(input string tag);
    chk({tag, "_escrita"}, {31'd0, escrita}, 32'd0);
    chk({tag, "_idreg"}, {30'd0, id_reg}, 32'd0);
    chk({tag, "_dado"}, dado, 32'd0);
    chk({tag, "_fonte1"}, {30'd0, fonte1}, 32'd0);
    chk({tag, "_fonte2"}, {30'd0, fonte2}, 32'd0);
    chk({tag, "_resultado"}, resultado, 32'd0);
    chk({tag, "_pronto"}, {31'd0, pronto}, 32'd0);
    chk({tag, "_ocupado"}, {31'd0, ocupado}, 32'd0);
    chk({tag, "_overflow"}, {31'd0, overflow}, 32'd0);
  endtask

  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input bit glitch, input bit rst_exec);
    logic [32:0] m;
    logic [1:0]  eid [3];
    logic [31:0] edat [3];
    int n, lat, rd_c, exec_c;
    bit acc, exp_esc;
    acc = (o == 3'd5);
    m = model(o, acc ? model_acc : a, b);
    if (acc) begin
      n = 2; eid[0] = 2'd1; edat[0] = b; eid[1] = 2'd2; edat[1] = m[31:0];
    end else begin
      n = 3; eid[0] = 2'd0; edat[0] = a; eid[1] = 2'd1; edat[1] = b;
      eid[2] = 2'd2; edat[2] = m[31:0];
    end
    rd_c = acc ? 2 : 3;
    exec_c = rd_c + 1;
    lat = -1;
    @(negedge clk);
    wlog.delete();
    start = 1'b1; op = o; op_a = a; op_b = b;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) begin
        start = 1'b0; op_a = ~a; op_b = $urandom;
        chk("ovf_cleared", {31'd0, overflow}, 32'd0);
      end
      if (glitch && k == 2) begin
        start = 1'b1; op = 3'd1; op_a = $urandom; op_b = $urandom;
      end
      if (glitch && k == 3) start = 1'b0;
      exp_esc = acc ? (k == 1 || k == 4) : (k == 1 || k == 2 || k == 5);
      if (k <= 6) chk("escrita_seq", {31'd0, escrita}, {31'd0, exp_esc});
      chk("ocupado_busy", {31'd0, ocupado}, 32'd1);
      if (k == rd_c) begin
        chk("fonte1_rd", {30'd0, fonte1}, acc ? 32'd2 : 32'd0);
        chk("fonte2_rd", {30'd0, fonte2}, 32'd1);
      end
      if (rst_exec && k == exec_c) begin
        rst = 1'b1;
        #1;
        check_all_zero("rst_exec");
        @(negedge clk);
        rst = 1'b0;
        chk("rst_exec_nwrites", wlog.size(), n - 1);
        return;
      end
      if (pronto) begin
        lat = k;
        break;
      end
    end
    chk("latency", lat, acc ? 32'd5 : 32'd6);
    chk("resultado", resultado, m[31:0]);
    chk("overflow", {31'd0, overflow}, {31'd0, m[32]});
    chk("nwrites", wlog.size(), n);
    for (int i = 0; i < n && i < wlog.size(); i++) begin
      chk("wr_id", {30'd0, wlog[i][33:32]}, {30'd0, eid[i]});
      chk("wr_data", wlog[i][31:0], edat[i]);
    end
    @(negedge clk);
    chk("idle_ocupado", {31'd0, ocupado}, 32'd0);
    chk("idle_pronto", {31'd0, pronto}, 32'd0);
    model_acc = m[31:0];
  endtask

  initial begin
    start = 1'b0; op = 3'd0; op_a = 32'd0; op_b = 32'd0;
    #1 rst = 1'b1;
    #2 check_all_zero("reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    run_op(3'd0, 32'd5, 32'd7, 1'b0, 1'b0);
    run_op(3'd1, 32'h8000_0000, 32'd1, 1'b0, 1'b0);
    run_op(3'd3, 32'h0000_00F0, 32'h0000_000F, 1'b0, 1'b0);
    run_op(3'd4, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0);
    run_op(3'd4, 32'd0, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run_op(3'd0, 32'd5, 32'd7, 1'b0, 1'b0);
    run_op(3'd5, 32'hDEAD_BEEF, 32'd3, 1'b0, 1'b0);
    run_op(3'd0, 32'd100, 32'd200, 1'b1, 1'b0);
    run_op(3'd0, 32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0);
    run_op(3'd1, 32'd10, 32'd3, 1'b0, 1'b1);
    run_op(3'd0, 32'd1, 32'd2, 1'b0, 1'b0);
    run_op(3'd5, 32'd0, 32'd1, 1'b0, 1'b0);

    // Reserved opcode must not start an operation.
    @(negedge clk);
    wlog.delete();
    start = 1'b1; op = 3'b110;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("reserved_ocupado", {31'd0, ocupado}, 32'd0);
    end
    start = 1'b0;
    chk("reserved_nwrites", wlog.size(), 32'd0);

    for (int i = 0; i < 12; i++) begin
      run_op(3'($urandom_range(0, 5)), $urandom, $urandom, 1'b0, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/calc_reg_sequencer.md
Name: calc_reg_sequencer

Overview:
- Initiator side of the calculator register-bank interface. Drives the bank's write port (IdReg, Escrita, Dado) and read selects (Fonte1, Fonte2), and consumes DadoLido1/DadoLido2.
- Per operation request, it loads the operands into registers 0 and 1, reads them back, executes the ALU operation internally and writes the result into the accumulator (register 2).
- Sits between the top-level calculator I/O and the register bank.

Parameters:
- ID_A, 2'b00, bank index of operand register A
- ID_B, 2'b01, bank index of operand register B
- ID_ACC, 2'b10, bank index of accumulator

Ports:
- Clock  input  1  single system clock, rising edge
- Reset  input  1  asynchronous, active-high reset
- Start  input  1  operation request, sampled only in IDLE
- Op  input  3  000 add, 001 sub, 010 and, 011 or, 100 slt (signed), 101 acc-add (ACC+B); 11x reserved
- OpA  input  32  operand A, captured on accepted Start
- OpB  input  32  operand B, captured on accepted Start
- IdReg  output  2  bank write index
- Escrita  output  1  bank write enable
- Dado  output  32  bank write data
- Fonte1  output  2  bank read select 1
- Fonte2  output  2  bank read select 2
- DadoLido1  input  32  bank read data 1, combinational from Fonte1
- DadoLido2  input  32  bank read data 2, combinational from Fonte2
- Resultado  output  32  last result, held until next result write
- Pronto  output  1  one-cycle done pulse
- Ocupado  output  1  high in every state except IDLE
- Overflow  output  1  signed overflow of last add/sub/acc-add, held until next accepted Start

Behaviour:
- Bank contract:
  - Bank writes Dado into register IdReg on the Clock rising edge while Escrita=1.
  - Read data is valid combinationally while Escrita=0.
  - Index 2'b11 is never driven.
- All control outputs (IdReg, Escrita, Dado, Fonte1, Fonte2, Pronto, Ocupado) are registered, decoded from the state register.
- Reset (asynchronous, any time, including mid-operation):
  - State goes to IDLE.
  - Escrita=0, IdReg=0, Dado=0, Fonte1=0, Fonte2=0, Resultado=0, Pronto=0, Ocupado=0, Overflow=0.
  - Captured operands are cleared and any in-flight operation is abandoned.
- States: IDLE, WR_A, WR_B, RD, EXEC, WR_ACC, DONE.
- IDLE:
  - Outputs: Escrita=0, Fonte1=ID_A, Fonte2=ID_B.
  - Start=1 with a non-reserved Op: capture OpA, OpB, Op; clear Overflow; go to WR_A, or to WR_B if Op=101.
  - Start=1 with reserved Op: ignored, stay in IDLE.
- WR_A: Escrita=1, IdReg=ID_A, Dado=OpA. Next state WR_B.
- WR_B: Escrita=1, IdReg=ID_B, Dado=OpB. Next state RD.
- RD:
  - Escrita=0, Fonte2=ID_B; Fonte1=ID_ACC if Op=101, else ID_A.
  - Capture DadoLido1 and DadoLido2 into internal registers X and Y at the end of the cycle. Next state EXEC.
- EXEC:
  - Escrita=0. Compute R from X and Y: add X+Y; sub X-Y; and; or; slt gives 32'd1 if signed X<Y, else 0; acc-add X+Y.
  - All arithmetic is 32-bit, wrap-around modulo 2^32.
  - Overflow: for add/acc-add, operand signs equal and result sign differs. For sub, operand signs differ and result sign differs from X. Other ops leave Overflow at 0.
  - Next state WR_ACC.
- WR_ACC: Escrita=1, IdReg=ID_ACC, Dado=R; Resultado updates to R on the same edge. Next state DONE.
- DONE: Pronto=1 for exactly this cycle, Escrita=0. Next state IDLE.
- Latency, counting the Start-sampling edge as cycle 0:
  - Normal ops: Pronto high in cycle 6.
  - Op=101: Pronto high in cycle 5.
- Back-to-back: Start can be accepted on the first IDLE cycle after DONE; minimum repetition is 7 cycles (6 for acc-add).
- Start while Ocupado=1 is ignored: no capture, no state change.
- OpA/OpB changing after capture have no effect.
- Escrita is never high in two different IdReg targets within the same cycle, and never high in RD, EXEC, DONE or IDLE.

Test Plan:
- Reset, then Start with Op=000, OpA=5, OpB=7 -> bank writes in order A=5, B=7, ACC=12; Pronto pulses in cycle 6; Resultado=12, Overflow=0.
- Op=001, OpA=32'h8000_0000, OpB=1 -> Resultado=32'h7FFF_FFFF, Overflow=1. Then Op=011, OpA=32'hF0, OpB=32'h0F -> Resultado=32'hFF, Overflow=0.
- Op=100, OpA=32'hFFFF_FFFF, OpB=0 -> Resultado=1; swap the operands -> Resultado=0.
- After ACC=12, Op=101, OpB=3 -> no write to register 0; Fonte1=2 in RD; Resultado=15; Pronto in cycle 5.
- Start pulsed again during WR_B with different operands -> ignored; result matches the first request; Ocupado stays high until after DONE.
- Reset asserted mid-EXEC -> Escrita=0 and all outputs 0 immediately (asynchronously); no ACC write occurs; the next Start runs normally.
